// File: rtl/axil_param_regbank.sv
// -----------------------------------------------------------------------------
// axil_param_regbank
//
// AXI4-Lite slave exposing a parameterised bank of C_NUM_REGS registers.
// Registers may be marked read-only (they read the matching hw_in word) or
// self-clearing (they hold a written value for one cycle, then return to 0).
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET        clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*                 write address, data and response channels
//   S_AXI_AR*/R*                    read address and data channels
//   reg_out   [C_NUM_REGS*DW]       flattened register contents, word i at i*DW
//   hw_in     [C_NUM_REGS*DW]       values returned by read-only registers
//   reg_wr_pulse [C_NUM_REGS]       one-cycle strobe after an OKAY write commit
// -----------------------------------------------------------------------------
module axil_param_regbank #(
    parameter int           C_S_AXI_DATA_WIDTH = 32,
    parameter int           C_S_AXI_ADDR_WIDTH = 6,
    parameter int           C_NUM_REGS         = 8,
    parameter logic [255:0] C_RO_MASK          = '0,
    parameter logic [255:0] C_PULSE_MASK       = '0
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic [2:0]                                 S_AXI_AWPROT,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic [2:0]                                 S_AXI_ARPROT,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_in,
    output logic [C_NUM_REGS-1:0]                      reg_wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = AW - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    // Word index is in range of the implemented bank.
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(C_NUM_REGS);
    endfunction

    function automatic logic idx_ro(input logic [IDX_W-1:0] idx);
        logic ro;
        ro = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (32'(idx) == 32'(i)) ro = C_RO_MASK[i];
        return ro;
    endfunction

    wr_state_t                      wr_state;
    logic [IDX_W-1:0]               aw_idx_q;
    logic [DW-1:0]                  w_data_q;
    logic [NB-1:0]                  w_strb_q;
    logic [C_NUM_REGS-1:0][DW-1:0]  regs;

    logic                           aw_hs;
    logic                           w_hs;
    logic                           ar_hs;
    logic                           commit_en;
    logic                           commit_ok;
    logic [1:0]                     commit_resp;
    logic [IDX_W-1:0]               commit_idx;
    logic [DW-1:0]                  commit_data;
    logic [NB-1:0]                  commit_strb;
    logic [IDX_W-1:0]               rd_idx;
    logic [DW-1:0]                  rd_data;
    logic [1:0]                     rd_resp;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign reg_out = regs;

    // Select the address/data that complete a write this cycle: whichever
    // channel arrived earlier comes from its holding register, the other from
    // the live bus.
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = S_AXI_AWADDR[AW-1:ADDR_LSB];
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (wr_state)
            WR_IDLE:    commit_en = aw_hs & w_hs;
            WR_HAVE_AW: begin
                commit_en  = w_hs;
                commit_idx = aw_idx_q;
            end
            WR_HAVE_W:  begin
                commit_en   = aw_hs;
                commit_data = w_data_q;
                commit_strb = w_strb_q;
            end
            default:    commit_en = 1'b0;
        endcase
        commit_resp = (idx_valid(commit_idx) && !idx_ro(commit_idx)) ? RESP_OKAY : RESP_SLVERR;
        commit_ok   = commit_en && (commit_resp == RESP_OKAY);
    end

    // Write FSM; READY/B outputs are registered and follow the next state.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state      <= WR_IDLE;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state      <= WR_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= commit_resp;
                    end else if (aw_hs) begin
                        wr_state      <= WR_HAVE_AW;
                        aw_idx_q      <= S_AXI_AWADDR[AW-1:ADDR_LSB];
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                    end else if (w_hs) begin
                        wr_state      <= WR_HAVE_W;
                        w_data_q      <= S_AXI_WDATA;
                        w_strb_q      <= S_AXI_WSTRB;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b0;
                    end else begin
                        // Also raises the READYs on the first edge after reset.
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                WR_HAVE_AW: begin
                    if (w_hs) begin
                        wr_state     <= WR_RESP;
                        S_AXI_WREADY <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= commit_resp;
                    end
                end
                WR_HAVE_W: begin
                    if (aw_hs) begin
                        wr_state      <= WR_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= commit_resp;
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        wr_state      <= WR_IDLE;
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Register bank. Pulse registers clear every cycle unless written, so a
    // committed value is visible for exactly one cycle.
    // NOTE: the bank is built from flops, not a RAM macro, so it can take the
    // asynchronous reset like any other state.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            regs         <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (C_PULSE_MASK[i]) regs[i] <= '0;
                if (commit_ok && (32'(commit_idx) == 32'(i))) begin
                    reg_wr_pulse[i] <= 1'b1;
                    for (int k = 0; k < NB; k++)
                        if (commit_strb[k]) regs[i][k*8 +: 8] <= commit_data[k*8 +: 8];
                end
            end
        end
    end

    // Read mux samples the bank before any same-edge write lands.
    always_comb begin
        rd_idx  = S_AXI_ARADDR[AW-1:ADDR_LSB];
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (32'(rd_idx) == 32'(i)) begin
                rd_resp = RESP_OKAY;
                rd_data = C_RO_MASK[i] ? hw_in[i*DW +: DW] : regs[i];
            end
        end
    end

    // Read channel: ARREADY is the registered complement of RVALID.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else if (S_AXI_RVALID) begin
            if (S_AXI_RREADY) begin
                S_AXI_RVALID  <= 1'b0;
                S_AXI_ARREADY <= 1'b1;
            end
        end else if (ar_hs) begin
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RDATA   <= rd_data;
            S_AXI_RRESP   <= rd_resp;
        end else begin
            S_AXI_ARREADY <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_param_regbank.sv
// -----------------------------------------------------------------------------
// tb_axil_param_regbank
//
// Directed bench for axil_param_regbank. Two instances share all inputs: one
// with default parameters, one with register 0 read-only and register 3
// self-clearing; sel_cfg chooses whose AXI outputs the tasks observe.
// Expected B/R responses are queued when a transaction is issued and popped
// when the observed instance presents the response.
// -----------------------------------------------------------------------------
module tb_axil_param_regbank;

    localparam int         DW     = 32;
    localparam int         AW     = 6;
    localparam int         NR     = 8;
    localparam int         TMO    = 50;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic            AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic [NR*DW-1:0] hw_in;

    logic            awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
    logic [1:0]      bresp_d, rresp_d;
    logic [DW-1:0]   rdata_d;
    logic [NR*DW-1:0] reg_out_d;
    logic [NR-1:0]   pulse_d;

    logic            awready_c, wready_c, bvalid_c, arready_c, rvalid_c;
    logic [1:0]      bresp_c, rresp_c;
    logic [DW-1:0]   rdata_c;
    logic [NR*DW-1:0] reg_out_c;
    logic [NR-1:0]   pulse_c;

    logic            sel_cfg;
    logic            awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
    logic [1:0]      bresp_m, rresp_m;
    logic [DW-1:0]   rdata_m;

    assign awready_m = sel_cfg ? awready_c : awready_d;
    assign wready_m  = sel_cfg ? wready_c  : wready_d;
    assign bvalid_m  = sel_cfg ? bvalid_c  : bvalid_d;
    assign bresp_m   = sel_cfg ? bresp_c   : bresp_d;
    assign arready_m = sel_cfg ? arready_c : arready_d;
    assign rvalid_m  = sel_cfg ? rvalid_c  : rvalid_d;
    assign rresp_m   = sel_cfg ? rresp_c   : rresp_d;
    assign rdata_m   = sel_cfg ? rdata_c   : rdata_d;

    axil_param_regbank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(awready_d),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(wready_d),
        .S_AXI_BRESP(bresp_d), .S_AXI_BVALID(bvalid_d), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(arready_d),
        .S_AXI_RDATA(rdata_d), .S_AXI_RRESP(rresp_d), .S_AXI_RVALID(rvalid_d), .S_AXI_RREADY(RREADY),
        .reg_out(reg_out_d), .hw_in(hw_in), .reg_wr_pulse(pulse_d)
    );

    axil_param_regbank #(
        .C_RO_MASK(256'h1),
        .C_PULSE_MASK(256'h8)
    ) dut_cfg (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(awready_c),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(wready_c),
        .S_AXI_BRESP(bresp_c), .S_AXI_BVALID(bvalid_c), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(arready_c),
        .S_AXI_RDATA(rdata_c), .S_AXI_RRESP(rresp_c), .S_AXI_RVALID(rvalid_c), .S_AXI_RREADY(RREADY),
        .reg_out(reg_out_c), .hw_in(hw_in), .reg_wr_pulse(pulse_c)
    );

    logic [1:0]    bq[$];
    rd_exp_t       rq[$];
    logic [DW-1:0] model [NR];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_bank();
        logic [NR*DW-1:0] b;
        for (int i = 0; i < NR; i++) b[i*DW +: DW] = model[i];
        return b;
    endfunction

    // Pop the expected write response and compare it with the observed BRESP.
    task automatic pop_b(input string tag);
        logic [1:0] e;
        check({tag, "_bq_nonempty"}, 256'(bq.size() != 0), 256'd1);
        if (bq.size() != 0) begin
            e = bq.pop_front();
            check({tag, "_bresp"}, 256'(bresp_m), 256'(e));
        end
    endtask

    // Issue AW and W together; the expected response is queued up front and
    // the default-instance model follows OKAY writes when upd is set.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb, input logic [1:0] exp, input logic upd);
        logic aw_done, w_done;
        bq.push_back(exp);
        if (upd && exp == OKAY)
            for (int k = 0; k < DW/8; k++)
                if (strb[k]) model[addr[AW-1:2]][k*8 +: 8] = data[k*8 +: 8];
        AWADDR = addr; AWVALID = 1'b1;
        WDATA  = data; WSTRB = strb; WVALID = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int n = 0; n < TMO && !(aw_done && w_done); n++) begin
            @(negedge clk);
            if (AWVALID && awready_m) aw_done = 1'b1;
            if (WVALID && wready_m) w_done = 1'b1;
            @(posedge clk); #1;
            if (aw_done) AWVALID = 1'b0;
            if (w_done)  WVALID  = 1'b0;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check($sformatf("wr_handshake@%0h", addr), 256'(aw_done && w_done), 256'd1);
    endtask

    task automatic wait_b(input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bvalid_m) begin
                got = 1'b1;
                pop_b(tag);
            end
        end
        check({tag, "_b_seen"}, 256'(got), 256'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
        logic done;
        rd_exp_t e;
        e.data = exp_data; e.resp = exp_resp;
        rq.push_back(e);
        ARADDR = addr; ARVALID = 1'b1; done = 1'b0;
        for (int n = 0; n < TMO && !done; n++) begin
            @(negedge clk);
            done = arready_m;
            @(posedge clk); #1;
        end
        ARVALID = 1'b0;
        check($sformatf("ar_handshake@%0h", addr), 256'(done), 256'd1);
        done = 1'b0;
        for (int n = 0; n < TMO && !done; n++) begin
            @(negedge clk);
            if (rvalid_m) begin
                done = 1'b1;
                check("rq_nonempty", 256'(rq.size() != 0), 256'd1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    check($sformatf("rdata@%0h", addr), 256'(rdata_m), 256'(e.data));
                    check($sformatf("rresp@%0h", addr), 256'(rresp_m), 256'(e.resp));
                end
            end
        end
        check($sformatf("r_seen@%0h", addr), 256'(done), 256'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; sel_cfg = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
        hw_in = '0;
        hw_in[DW-1:0] = 32'hDEAD_BEEF;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state and READY release timing.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 256'(awready_d), 256'd0);
        check("rst_wready",  256'(wready_d),  256'd0);
        check("rst_arready", 256'(arready_d), 256'd0);
        check("rst_bvalid",  256'(bvalid_d),  256'd0);
        check("rst_rvalid",  256'(rvalid_d),  256'd0);
        check("rst_rdata",   256'(rdata_d),   256'd0);
        check("rst_reg_out", 256'(reg_out_d), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_awready_before_edge", 256'(awready_d), 256'd0);
        @(negedge clk);
        check("release_awready", 256'(awready_d), 256'd1);
        check("release_wready",  256'(wready_d),  256'd1);
        check("release_arready", 256'(arready_d), 256'd1);
        @(posedge clk); #1;

        // Basic write then readback of four words.
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i*4), 32'(i+1), 4'hF, OKAY, 1'b1);
            wait_b("wr_basic");
        end
        for (int i = 0; i < 4; i++) axi_read(6'(i*4), 32'(i+1), OKAY);
        check("bank_after_basic", 256'(reg_out_d), 256'(model_bank()));

        // W leads AW by three cycles.
        bq.push_back(OKAY);
        model[2] = 32'hA5A5_A5A5;
        WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge clk);
        check("wfirst_wready", 256'(wready_d), 256'd1);
        @(posedge clk); #1;
        WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("have_w_awready", 256'(awready_d), 256'd1);
            check("have_w_wready",  256'(wready_d),  256'd0);
            check("have_w_bvalid",  256'(bvalid_d),  256'd0);
            @(posedge clk); #1;
        end
        AWADDR = 6'h08; AWVALID = 1'b1;
        @(negedge clk);
        check("wfirst_awready", 256'(awready_d), 256'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        @(negedge clk);
        check("wfirst_bvalid", 256'(bvalid_d), 256'd1);
        pop_b("wfirst");
        check("wfirst_word2", 256'(reg_out_d[2*DW +: DW]), 256'h0A5A5_A5A5);
        check("wfirst_pulse_hi", 256'(pulse_d), 256'h04);
        @(posedge clk); #1;
        @(negedge clk);
        check("wfirst_pulse_lo", 256'(pulse_d), 256'h00);
        check("wfirst_bvalid_lo", 256'(bvalid_d), 256'd0);
        @(posedge clk); #1;

        // Byte strobes update only the enabled lanes.
        axi_write(6'h04, 32'h1122_3344, 4'hF, OKAY, 1'b1);
        wait_b("strb_init");
        axi_write(6'h04, 32'hFFFF_FFFF, 4'h6, OKAY, 1'b1);
        wait_b("strb_partial");
        axi_read(6'h04, 32'h11FF_FF44, OKAY);

        // Out-of-range index.
        axi_write(6'h20, 32'hCAFE_F00D, 4'hF, SLVERR, 1'b1);
        wait_b("oor_write");
        axi_read(6'h20, 32'h0, SLVERR);
        check("bank_after_oor", 256'(reg_out_d), 256'(model_bank()));

        // Read-only register 0 on the configured instance.
        sel_cfg = 1'b1;
        axi_write(6'h00, 32'h1234_5678, 4'hF, SLVERR, 1'b0);
        wait_b("ro_write");
        axi_read(6'h00, 32'hDEAD_BEEF, OKAY);

        // Self-clearing register 3 on the configured instance.
        axi_write(6'h0C, 32'h5, 4'hF, OKAY, 1'b0);
        @(negedge clk);
        check("pulse_bvalid", 256'(bvalid_c), 256'd1);
        pop_b("pulse_reg");
        check("pulse_word3_hi", 256'(reg_out_c[3*DW +: DW]), 256'h5);
        check("pulse_strobe", 256'(pulse_c), 256'h08);
        @(posedge clk); #1;
        @(negedge clk);
        check("pulse_word3_lo", 256'(reg_out_c[3*DW +: DW]), 256'h0);
        @(posedge clk); #1;
        sel_cfg = 1'b0;

        // Back-pressure on B: response and READYs must hold.
        BREADY = 1'b0;
        axi_write(6'h24, 32'h0BAD_0BAD, 4'hF, SLVERR, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_bvalid",  256'(bvalid_d),  256'd1);
            check("bp_bresp",   256'(bresp_d),   256'(SLVERR));
            check("bp_awready", 256'(awready_d), 256'd0);
        end
        pop_b("bp");
        BREADY = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_bvalid_released", 256'(bvalid_d), 256'd0);
        @(posedge clk); #1;

        // Reset while holding an accepted AW: nothing may commit.
        AWADDR = 6'h14; AWVALID = 1'b1;
        @(negedge clk);
        check("mid_awready", 256'(awready_d), 256'd1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        @(negedge clk);
        check("have_aw_wready",  256'(wready_d),  256'd1);
        check("have_aw_awready", 256'(awready_d), 256'd0);
        rst = 1'b1;
        WDATA = 32'h9999_9999; WSTRB = 4'hF; WVALID = 1'b1;
        #1;
        check("mid_rst_awready", 256'(awready_d), 256'd0);
        check("mid_rst_wready",  256'(wready_d),  256'd0);
        check("mid_rst_arready", 256'(arready_d), 256'd0);
        check("mid_rst_reg_out", 256'(reg_out_d), 256'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        check("mid_rel_awready_early", 256'(awready_d), 256'd0);
        @(negedge clk);
        check("mid_rel_awready", 256'(awready_d), 256'd1);
        check("mid_rel_wready",  256'(wready_d),  256'd1);
        @(posedge clk); #1;
        // A lone W must now park in WR_HAVE_W instead of completing the old AW.
        WVALID = 1'b1;
        @(negedge clk);
        check("post_rst_wready", 256'(wready_d), 256'd1);
        @(posedge clk); #1;
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_bvalid", 256'(bvalid_d), 256'd0);
            check("post_rst_awready",   256'(awready_d), 256'd1);
        end
        check("post_rst_word5", 256'(reg_out_d[5*DW +: DW]), 256'h0);
        check("bq_drained", 256'(bq.size()), 256'd0);
        check("rq_drained", 256'(rq.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
